// File: rtl/seq_carry_select_adder.sv
// Multi-cycle carry-select adder: sums CHUNK bits per clock, choosing between carry-in 0/1 results.
// Optional signed-overflow flag enabled by defining OVF_FLAG_EN.
module seq_carry_select_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVF_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [IdxW-1:0]   idx_q, idx_d;
`ifdef OVF_FLAG_EN
  logic              ovf_q, ovf_d;
`endif

  int unsigned       base;
  logic [CHUNK-1:0]  a_c, b_c;
  logic [CHUNK:0]    s0, s1, sel;

  always_comb begin
    base = 32'(idx_q) * CHUNK;
    a_c  = a_q[base +: CHUNK];
    b_c  = b_q[base +: CHUNK];
    s0   = {1'b0, a_c} + {1'b0, b_c};
    s1   = s0 + {{CHUNK{1'b0}}, 1'b1};
  end

  // One 2:1 mux cell per bit; the registered chunk carry is the common select.
  for (genvar i = 0; i <= CHUNK; i++) begin : g_mux
    assign sel[i] = carry_q ? s1[i] : s0[i];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[base +: CHUNK] = sel[CHUNK-1:0];
        carry_d              = sel[CHUNK];
        idx_d                = idx_q + IdxW'(1);
        if (idx_q == IdxW'(N - 1)) begin
          cout_d  = sel[CHUNK];
`ifdef OVF_FLAG_EN
          // sel[CHUNK-1] is the MSB of the full sum on the last chunk.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sel[CHUNK-1] != a_q[WIDTH-1]);
`endif
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef OVF_FLAG_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_carry_select_adder.sv
// Self-checking bench for seq_carry_select_adder: directed vector table, corner sequences and
// randomized operations against a plain-arithmetic reference.
module tb_seq_carry_select_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
`ifdef OVF_FLAG_EN
  logic        overflow;
`endif

  int errors = 0;
  int checks = 0;

  seq_carry_select_adder #(.WIDTH(64), .CHUNK(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef OVF_FLAG_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic on a 65-bit result.
  task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic mc,
                       output logic [63:0] ms, output logic mco, output logic mov);
    logic [64:0] r;
    r   = {1'b0, ma} + {1'b0, mb} + {64'd0, mc};
    ms  = r[63:0];
    mco = r[64];
    mov = (ma[63] == mb[63]) && (r[63] != ma[63]);
  endtask

  // Starts and ends on a falling edge with out_ready held high.
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb2, input logic tc,
                        input logic [63:0] es, input logic ec, input logic eo,
                        input string tag);
    int lat;
    check({tag, ".in_ready_pre"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb2;
    cin      = tc;
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'd4);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, {63'd0, cout}, {63'd0, ec});
`ifdef OVF_FLAG_EN
    check({tag, ".overflow"}, {63'd0, overflow}, {63'd0, eo});
`else
    if (eo === 1'bx) $display("note: unused overflow expectation");
`endif
    @(negedge clk);
    check({tag, ".out_valid_drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] rs, held;
    logic        rc, ro, heldc;
    int          lat;

    vecs[0] = '{64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0};
    vecs[4] = '{64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};
    vecs[6] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[7] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0000_FFFF_0000, 1'b1,
                64'h0001_0000_0000_0000, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset.in_ready", {63'd0, in_ready}, 64'd1);
    check("reset.out_valid", {63'd0, out_valid}, 64'd0);
    check("reset.sum", sum, 64'd0);
    check("reset.cout", {63'd0, cout}, 64'd0);
`ifdef OVF_FLAG_EN
    check("reset.overflow", {63'd0, overflow}, 64'd0);
`endif

    // Directed table; entries 3 and 4 run back-to-back as the 3+4 / 10+20 pair.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
             $sformatf("vec%0d", i));

    // Stall in DONE for 3 cycles while pulsing in_valid with other operands.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 64'h0123_4567_89AB_CDEF;
    b         = 64'h1111_1111_1111_1111;
    cin       = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("stall.latency", 64'(lat), 64'd4);
    held  = sum;
    heldc = cout;
    check("stall.sum", held, 64'h1234_5678_9ABC_DF00);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a        = 64'hDEAD_BEEF_0000_0000 + 64'(k);
      b        = 64'h0BAD_F00D_0000_0000;
      @(negedge clk);
      check($sformatf("stall%0d.out_valid", k), {63'd0, out_valid}, 64'd1);
      check($sformatf("stall%0d.in_ready", k), {63'd0, in_ready}, 64'd0);
      check($sformatf("stall%0d.sum", k), sum, 64'h1234_5678_9ABC_DF00);
      check($sformatf("stall%0d.cout", k), {63'd0, cout}, {63'd0, heldc});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall.release", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("stall.idle_after", {63'd0, in_ready}, 64'd1);
    check("stall.sum_kept", sum, 64'h1234_5678_9ABC_DF00);

    // Reset asserted across the edge ending the second RUN cycle.
    in_valid = 1'b1;
    a        = 64'hFFFF_0000_FFFF_0000;
    b        = 64'h0001_0001_0001_0001;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.in_ready", {63'd0, in_ready}, 64'd1);
    check("abort.out_valid", {63'd0, out_valid}, 64'd0);
    check("abort.sum", sum, 64'd0);
    check("abort.cout", {63'd0, cout}, 64'd0);
    lat = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    check("abort.no_valid_pulse", 64'(lat), 64'd0);
    run_op(64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0, "after_abort");

    // Randomized operations, some biased towards long carry chains.
    for (int i = 0; i < 40; i++) begin
      logic [63:0] ra, rb;
      logic        rci;
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rci = 1'($urandom);
      if (i % 4 == 1) rb = ~ra;
      if (i % 4 == 2) ra = 64'hFFFF_FFFF_FFFF_FFFF;
      model(ra, rb, rci, rs, rc, ro);
      run_op(ra, rb, rci, rs, rc, ro, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
